execute_pipe: RTL and testbench
===============================

EXECUTE_PIPE -- requirements
Module: execute_pipe

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, datapath width in bits (legal 8..64).
REQ-002 SHALL provide parameter REG_BITS, default 5, register-specifier width.
REQ-003 SHALL provide ports:
- clk  in  1  sole clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  ID/EX bundle present.
- in_ready  out  1  bundle accepted when in_valid & in_ready at clk edge.
- flush  in  1  discard EX/MEM contents and any in-flight multiply.
- ctlwb_in  in  2  WB control.
- ctlm_in  in  3  {branch, memread, memwrite}.
- npc, rdata1, rdata2, s_extend  in  WIDTH each  next PC, rs, rt, sign-extended immediate.
- instr_2016, instr_1511  in  REG_BITS each  rt and rd fields.
- alu_op  in  2; funct  in  6; alusrc  in  1; regdst  in  1.
- fwd_a, fwd_b  in  2 each  operand-forward selects.
- wb_data  in  WIDTH  write-back value for forwarding.
- out_valid  out  1  EX/MEM holds a valid instruction.
- ctlwb_out  out  2; ctlm_out  out  3.
- adder_out, alu_result_out, rdata2_out  out  WIDTH each.
- zero_out  out  1; muxout_out  out  REG_BITS.

Function
REQ-004 Operand A SHALL be: fwd_a=00 rdata1; 01 alu_result_out (current EX/MEM register); 10 wb_data; 11 rdata1.
REQ-005 Forwarded B SHALL use the same encoding via fwd_b on rdata2; ALU B = s_extend if alusrc=1, else forwarded B; rdata2_out SHALL capture forwarded B.
REQ-006 ALU function: alu_op 00 add; 01 sub; 11 add; 10 decode funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 signed slt (result 1 or 0), 011000 mult; any other funct gives result 0.
REQ-007 Add/sub SHALL wrap modulo 2^WIDTH; zero_out = (result == 0).
REQ-008 adder_out SHALL be npc + s_extend modulo 2^WIDTH.
REQ-009 muxout_out SHALL be instr_1511 if regdst=1, else instr_2016.
REQ-010 State machine SHALL have two states, IDLE and MUL; in_ready = 1 in IDLE, 0 in MUL.
REQ-011 In IDLE, an accepted non-mult bundle SHALL load all EX/MEM outputs and out_valid=1 at the same edge (latency 1).
REQ-012 In IDLE with no accept, out_valid SHALL go 0 at the edge; other EX/MEM fields hold.
REQ-013 An accepted mult SHALL latch operands, control, dest, npc-sum and rdata2 at accept edge N, enter MUL, and set out_valid=0.
REQ-014 In MUL, the unit SHALL perform one shift-add iteration per cycle over a count of 0..WIDTH-1, producing the low WIDTH bits of A*B (unsigned).
REQ-015 At edge N+WIDTH, the unit SHALL write the mult result and latched fields to EX/MEM, set out_valid=1, and return to IDLE; in_ready is high in the following cycle.
REQ-016 out_valid SHALL remain 0 on edges N+1..N+WIDTH-1.
REQ-017 Flush SHALL take priority over accept and completion: at that edge out_valid=0, state=IDLE, count=0, the bundle is not accepted, and in_ready=1 next cycle.
REQ-018 When in_valid=0, data inputs SHALL be ignored; no output other than out_valid changes.

Reset
REQ-019 Reset SHALL take priority over flush and accept.
REQ-020 When reset is high at an edge, state SHALL be IDLE and count 0, with every EX/MEM output cleared: out_valid 0, ctlwb_out 0, ctlm_out 0, adder_out 0, alu_result_out 0, rdata2_out 0, zero_out 0, muxout_out 0.
REQ-021 Reset asserted during MUL SHALL abort the multiply, and no result SHALL be produced.

Verification
REQ-022 Bench SHALL cover these directed scenarios (WIDTH=32):
- R-add: rdata1=5, rdata2=7, alu_op=10, funct=100000, regdst=1, rd=3, accepted → next edge out_valid=1, alu_result_out=12, zero_out=0, muxout_out=3.
- beq-sub with branch target: rdata1=rdata2=9, alu_op=01, npc=0x100, s_extend=0xFFFFFFFC, ctlm_in=100 → alu_result_out=0, zero_out=1, adder_out=0xFC, ctlm_out=100.
- Forwarding: EX/MEM holds 20, fwd_a=01, fwd_b=10, wb_data=3, funct=slt → alu_result_out=0; a sw with fwd_b=10 gives rdata2_out=3.
- Multiply: 0xFFFF×0x10001 accepted at edge N → in_ready=0 and out_valid=0 through edge N+31; at edge N+32 alu_result_out=0xFFFFFFFF and out_valid=1; a bundle held on in_valid during MUL is accepted only after return to IDLE.
- Flush/reset mid-multiply: flush at count 10 → out_valid never rises and in_ready=1 next cycle; reset at count 5 → all outputs 0.
- Overflow wrap: add 0xFFFFFFFF+1 → alu_result_out=0, zero_out=1.

Source files
------------

// File: rtl/execute_pipe.sv
// Execute stage: operand forwarding, ALU, branch-target adder and a
// multi-cycle shift-add multiplier feeding the EX/MEM pipeline register.
module execute_pipe #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned REG_BITS = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                flush,
    input  logic [1:0]          ctlwb_in,
    input  logic [2:0]          ctlm_in,
    input  logic [WIDTH-1:0]    npc,
    input  logic [WIDTH-1:0]    rdata1,
    input  logic [WIDTH-1:0]    rdata2,
    input  logic [WIDTH-1:0]    s_extend,
    input  logic [REG_BITS-1:0] instr_2016,
    input  logic [REG_BITS-1:0] instr_1511,
    input  logic [1:0]          alu_op,
    input  logic [5:0]          funct,
    input  logic                alusrc,
    input  logic                regdst,
    input  logic [1:0]          fwd_a,
    input  logic [1:0]          fwd_b,
    input  logic [WIDTH-1:0]    wb_data,
    output logic                out_valid,
    output logic [1:0]          ctlwb_out,
    output logic [2:0]          ctlm_out,
    output logic [WIDTH-1:0]    adder_out,
    output logic [WIDTH-1:0]    alu_result_out,
    output logic [WIDTH-1:0]    rdata2_out,
    output logic                zero_out,
    output logic [REG_BITS-1:0] muxout_out
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {IDLE, MUL} state_t;

    state_t              state;
    logic [CNT_W-1:0]    count;

    logic [WIDTH-1:0]    op_a_c, op_b_fwd_c, alu_b_c, alu_res_c, adder_c;
    logic [WIDTH-1:0]    mul_next_c;
    logic [REG_BITS-1:0] dest_c;
    logic                is_mult_c;

    // Multiplier working registers and the fields parked until completion
    logic [WIDTH-1:0]    m_a, m_b, m_prod, m_adder, m_rdata2;
    logic [1:0]          m_ctlwb;
    logic [2:0]          m_ctlm;
    logic [REG_BITS-1:0] m_dest;

    // Forwarding muxes, ALU and target adder
    always_comb begin
        op_a_c     = rdata1;
        op_b_fwd_c = rdata2;
        alu_res_c  = '0;
        is_mult_c  = 1'b0;

        case (fwd_a)
            2'b01:   op_a_c = alu_result_out;
            2'b10:   op_a_c = wb_data;
            default: op_a_c = rdata1;
        endcase
        case (fwd_b)
            2'b01:   op_b_fwd_c = alu_result_out;
            2'b10:   op_b_fwd_c = wb_data;
            default: op_b_fwd_c = rdata2;
        endcase

        alu_b_c = alusrc ? s_extend : op_b_fwd_c;
        adder_c = npc + s_extend;
        dest_c  = regdst ? instr_1511 : instr_2016;

        case (alu_op)
            2'b01: alu_res_c = op_a_c - alu_b_c;
            2'b10: begin
                case (funct)
                    6'b100000: alu_res_c = op_a_c + alu_b_c;
                    6'b100010: alu_res_c = op_a_c - alu_b_c;
                    6'b100100: alu_res_c = op_a_c & alu_b_c;
                    6'b100101: alu_res_c = op_a_c | alu_b_c;
                    6'b101010: alu_res_c = WIDTH'($signed(op_a_c) < $signed(alu_b_c));
                    6'b011000: is_mult_c = 1'b1;
                    default:   alu_res_c = '0;
                endcase
            end
            default: alu_res_c = op_a_c + alu_b_c;
        endcase

        mul_next_c = m_b[0] ? (m_prod + m_a) : m_prod;
    end

    // EX/MEM register and IDLE/MUL sequencing
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            count          <= '0;
            in_ready       <= 1'b1;
            out_valid      <= 1'b0;
            ctlwb_out      <= '0;
            ctlm_out       <= '0;
            adder_out      <= '0;
            alu_result_out <= '0;
            rdata2_out     <= '0;
            zero_out       <= 1'b0;
            muxout_out     <= '0;
            m_a            <= '0;
            m_b            <= '0;
            m_prod         <= '0;
            m_adder        <= '0;
            m_rdata2       <= '0;
            m_ctlwb        <= '0;
            m_ctlm         <= '0;
            m_dest         <= '0;
        end else if (flush) begin
            state     <= IDLE;
            count     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    out_valid <= 1'b0;
                    if (in_valid && in_ready) begin
                        if (is_mult_c) begin
                            state    <= MUL;
                            in_ready <= 1'b0;
                            count    <= '0;
                            m_a      <= op_a_c;
                            m_b      <= alu_b_c;
                            m_prod   <= '0;
                            m_adder  <= adder_c;
                            m_rdata2 <= op_b_fwd_c;
                            m_ctlwb  <= ctlwb_in;
                            m_ctlm   <= ctlm_in;
                            m_dest   <= dest_c;
                        end else begin
                            out_valid      <= 1'b1;
                            ctlwb_out      <= ctlwb_in;
                            ctlm_out       <= ctlm_in;
                            adder_out      <= adder_c;
                            alu_result_out <= alu_res_c;
                            rdata2_out     <= op_b_fwd_c;
                            zero_out       <= (alu_res_c == '0);
                            muxout_out     <= dest_c;
                        end
                    end
                end
                MUL: begin
                    if (count == LAST_CNT) begin
                        state          <= IDLE;
                        in_ready       <= 1'b1;
                        count          <= '0;
                        out_valid      <= 1'b1;
                        ctlwb_out      <= m_ctlwb;
                        ctlm_out       <= m_ctlm;
                        adder_out      <= m_adder;
                        alu_result_out <= mul_next_c;
                        rdata2_out     <= m_rdata2;
                        zero_out       <= (mul_next_c == '0);
                        muxout_out     <= m_dest;
                    end else begin
                        m_prod <= mul_next_c;
                        m_a    <= m_a << 1;
                        m_b    <= m_b >> 1;
                        count  <= count + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_execute_pipe.sv
// Self-checking bench for execute_pipe: directed scenarios then randomized
// bundles compared against an arithmetic reference model.
module tb_execute_pipe;

    localparam int unsigned WIDTH    = 32;
    localparam int unsigned REG_BITS = 5;

    logic                clk = 1'b0;
    logic                reset, in_valid, flush, alusrc, regdst;
    logic                in_ready, out_valid, zero_out;
    logic [1:0]          ctlwb_in, alu_op, fwd_a, fwd_b, ctlwb_out;
    logic [2:0]          ctlm_in, ctlm_out;
    logic [5:0]          funct;
    logic [WIDTH-1:0]    npc, rdata1, rdata2, s_extend, wb_data;
    logic [WIDTH-1:0]    adder_out, alu_result_out, rdata2_out;
    logic [REG_BITS-1:0] instr_2016, instr_1511, muxout_out;

    int checks   = 0;
    int failures = 0;

    execute_pipe #(.WIDTH(WIDTH), .REG_BITS(REG_BITS)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .ctlwb_in(ctlwb_in), .ctlm_in(ctlm_in), .npc(npc),
        .rdata1(rdata1), .rdata2(rdata2), .s_extend(s_extend),
        .instr_2016(instr_2016), .instr_1511(instr_1511), .alu_op(alu_op),
        .funct(funct), .alusrc(alusrc), .regdst(regdst), .fwd_a(fwd_a),
        .fwd_b(fwd_b), .wb_data(wb_data), .out_valid(out_valid),
        .ctlwb_out(ctlwb_out), .ctlm_out(ctlm_out), .adder_out(adder_out),
        .alu_result_out(alu_result_out), .rdata2_out(rdata2_out),
        .zero_out(zero_out), .muxout_out(muxout_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        in_valid = 0; flush = 0; ctlwb_in = 0; ctlm_in = 0; npc = 0;
        rdata1 = 0; rdata2 = 0; s_extend = 0; instr_2016 = 0; instr_1511 = 0;
        alu_op = 0; funct = 0; alusrc = 0; regdst = 0; fwd_a = 0; fwd_b = 0;
        wb_data = 0;
    endtask

    // Reference ALU from the instruction rules, multiply as plain arithmetic
    function automatic logic [WIDTH-1:0] ref_alu(input logic [1:0] op, input logic [5:0] fn,
                                                 input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [63:0] p;
        if (op == 2'b01) return a - b;
        if (op != 2'b10) return a + b;
        case (fn)
            6'b100000: return a + b;
            6'b100010: return a - b;
            6'b100100: return a & b;
            6'b100101: return a | b;
            6'b101010: return (int'($signed(a)) < int'($signed(b))) ? 1 : 0;
            6'b011000: begin p = 64'(a) * 64'(b); return p[WIDTH-1:0]; end
            default:   return 0;
        endcase
    endfunction

    logic [WIDTH-1:0] exp_alu, exp_a, exp_bf, exp_b, exp_adder;
    logic [5:0]       funct_tbl [7];
    logic             is_mul;

    initial begin
        funct_tbl[0] = 6'b100000; funct_tbl[1] = 6'b100010; funct_tbl[2] = 6'b100100;
        funct_tbl[3] = 6'b100101; funct_tbl[4] = 6'b101010; funct_tbl[5] = 6'b011000;
        funct_tbl[6] = 6'b000111;
        clear_in();

        // Reset
        reset = 1; tick(); reset = 0;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_fields", {ctlwb_out, ctlm_out, adder_out, alu_result_out, rdata2_out, zero_out, muxout_out}, 0);

        // R-add
        in_valid = 1; rdata1 = 5; rdata2 = 7; alu_op = 2'b10; funct = 6'b100000;
        regdst = 1; instr_1511 = 3; instr_2016 = 9; ctlwb_in = 2'b11;
        tick();
        check("radd_valid", out_valid, 1);
        check("radd_alu", alu_result_out, 12);
        check("radd_zero", zero_out, 0);
        check("radd_mux", muxout_out, 3);
        check("radd_wb", ctlwb_out, 2'b11);
        clear_in(); rdata1 = 99; tick();
        check("idle_valid_low", out_valid, 0);
        check("idle_alu_hold", alu_result_out, 12);
        check("idle_mux_hold", muxout_out, 3);

        // beq-sub with branch target
        in_valid = 1; rdata1 = 9; rdata2 = 9; alu_op = 2'b01; npc = 32'h100;
        s_extend = 32'hFFFF_FFFC; ctlm_in = 3'b100; instr_2016 = 6;
        tick();
        check("beq_alu", alu_result_out, 0);
        check("beq_zero", zero_out, 1);
        check("beq_adder", adder_out, 32'hFC);
        check("beq_ctlm", ctlm_out, 3'b100);
        check("beq_mux", muxout_out, 6);

        // Forwarding: load 20, then slt forwarded 20 < 3, then sw with forwarded B
        clear_in(); in_valid = 1; rdata1 = 20; tick();
        check("fwd_load", alu_result_out, 20);
        clear_in(); in_valid = 1; fwd_a = 2'b01; fwd_b = 2'b10; wb_data = 3;
        alu_op = 2'b10; funct = 6'b101010; rdata1 = 1; rdata2 = 100; tick();
        check("fwd_slt", alu_result_out, 0);
        check("fwd_slt_zero", zero_out, 1);
        clear_in(); in_valid = 1; alusrc = 1; s_extend = 4; rdata1 = 100;
        rdata2 = 77; fwd_b = 2'b10; wb_data = 3; ctlm_in = 3'b001; tick();
        check("sw_rdata2", rdata2_out, 3);
        check("sw_alu", alu_result_out, 104);
        check("sw_ctlm", ctlm_out, 3'b001);

        // Multiply with a bundle held during MUL
        clear_in(); in_valid = 1; rdata1 = 32'hFFFF; rdata2 = 32'h10001;
        alu_op = 2'b10; funct = 6'b011000; npc = 32'h40; s_extend = 32'h10;
        regdst = 1; instr_1511 = 17; ctlwb_in = 2'b10;
        tick();
        check("mul_accept_ready", in_ready, 0);
        check("mul_accept_valid", out_valid, 0);
        clear_in(); in_valid = 1; rdata1 = 1; rdata2 = 2; npc = 32'h999;
        for (int i = 1; i < WIDTH; i++) begin
            tick();
            check($sformatf("mul_busy_valid_%0d", i), out_valid, 0);
            check($sformatf("mul_busy_ready_%0d", i), in_ready, 0);
        end
        tick();
        check("mul_done_valid", out_valid, 1);
        check("mul_done_alu", alu_result_out, 32'hFFFF_FFFF);
        check("mul_done_adder", adder_out, 32'h50);
        check("mul_done_mux", muxout_out, 17);
        check("mul_done_wb", ctlwb_out, 2'b10);
        check("mul_done_rdata2", rdata2_out, 32'h10001);
        check("mul_done_ready", in_ready, 1);
        tick();
        check("held_accept_valid", out_valid, 1);
        check("held_accept_alu", alu_result_out, 3);

        // Flush beats accept in IDLE
        clear_in(); in_valid = 1; rdata1 = 40; flush = 1; tick(); flush = 0; in_valid = 0;
        check("flush_idle_valid", out_valid, 0);
        check("flush_idle_alu_hold", alu_result_out, 3);

        // Flush at count 10
        clear_in(); in_valid = 1; rdata1 = 6; rdata2 = 7; alu_op = 2'b10; funct = 6'b011000;
        tick(); in_valid = 0;
        repeat (10) tick();
        flush = 1; tick(); flush = 0;
        check("flush_mul_ready", in_ready, 1);
        check("flush_mul_valid", out_valid, 0);
        for (int i = 0; i < WIDTH; i++) begin
            tick();
            check($sformatf("flush_no_result_%0d", i), out_valid, 0);
        end
        check("flush_alu_hold", alu_result_out, 3);

        // Reset at count 5
        clear_in(); in_valid = 1; rdata1 = 6; rdata2 = 7; alu_op = 2'b10; funct = 6'b011000;
        tick(); in_valid = 0;
        repeat (5) tick();
        reset = 1; tick(); reset = 0;
        check("rstmul_fields", {out_valid, ctlwb_out, ctlm_out, adder_out, alu_result_out, rdata2_out, zero_out, muxout_out}, 0);
        check("rstmul_ready", in_ready, 1);
        repeat (WIDTH) tick();
        check("rstmul_no_result", {out_valid, alu_result_out}, 0);

        // Overflow wrap
        clear_in(); in_valid = 1; rdata1 = 32'hFFFF_FFFF; rdata2 = 1; tick();
        check("wrap_alu", alu_result_out, 0);
        check("wrap_zero", zero_out, 1);

        // Randomized bundles against the reference model
        exp_alu = 0;
        for (int it = 0; it < 60; it++) begin
            clear_in();
            in_valid = ($urandom_range(0, 3) != 0);
            ctlwb_in = 2'($urandom); ctlm_in = 3'($urandom);
            npc = $urandom; rdata1 = $urandom; rdata2 = $urandom; s_extend = $urandom;
            if ($urandom_range(0, 3) == 0) rdata2 = rdata1;
            wb_data = $urandom; instr_2016 = 5'($urandom); instr_1511 = 5'($urandom);
            alu_op = 2'($urandom); funct = funct_tbl[$urandom_range(0, 6)];
            alusrc = 1'($urandom); regdst = 1'($urandom);
            fwd_a = 2'($urandom); fwd_b = 2'($urandom);

            exp_a  = (fwd_a == 2'b01) ? exp_alu : (fwd_a == 2'b10) ? wb_data : rdata1;
            exp_bf = (fwd_b == 2'b01) ? exp_alu : (fwd_b == 2'b10) ? wb_data : rdata2;
            exp_b  = alusrc ? s_extend : exp_bf;
            exp_adder = npc + s_extend;
            is_mul = in_valid && alu_op == 2'b10 && funct == 6'b011000;
            tick();
            if (!in_valid) begin
                check($sformatf("rnd%0d_idle_valid", it), out_valid, 0);
                check($sformatf("rnd%0d_idle_hold", it), alu_result_out, exp_alu);
                continue;
            end
            exp_alu = ref_alu(alu_op, funct, exp_a, exp_b);
            if (is_mul) begin
                check($sformatf("rnd%0d_mul_ready", it), in_ready, 0);
                in_valid = 0;
                repeat (WIDTH - 1) tick();
                check($sformatf("rnd%0d_mul_pending", it), out_valid, 0);
                tick();
            end
            check($sformatf("rnd%0d_valid", it), out_valid, 1);
            check($sformatf("rnd%0d_alu", it), alu_result_out, exp_alu);
            check($sformatf("rnd%0d_zero", it), zero_out, exp_alu == 0);
            check($sformatf("rnd%0d_adder", it), adder_out, exp_adder);
            check($sformatf("rnd%0d_rdata2", it), rdata2_out, exp_bf);
            check($sformatf("rnd%0d_ctl", it), {ctlwb_out, ctlm_out}, {ctlwb_in, ctlm_in});
            check($sformatf("rnd%0d_mux", it), muxout_out, regdst ? instr_1511 : instr_2016);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
